// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the FND scan-bus decoder.
// Glyphs are active-low g..a; select codes are active-low one-hot.
package fnd_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [3:0] COM_DIG0  = 4'b1110;
  localparam logic [3:0] COM_DIG1  = 4'b1101;
  localparam logic [3:0] COM_DIG2  = 4'b1011;
  localparam logic [3:0] COM_DIG3  = 4'b0111;
  localparam logic [3:0] COM_BLANK = 4'b1111;

  typedef enum logic {
    IDLE,
    CAPTURE
  } fsm_e;

  function automatic logic [13:0] bcd_to_bin(
    input logic [15:0] d
  );
    return 14'(d[15:12]) * 14'd1000
         + 14'(d[11:8])  * 14'd100
         + 14'(d[7:4])   * 14'd10
         + 14'(d[3:0]);
  endfunction

endpackage

// File: rtl/fnd_seg_to_bcd.sv
// Combinational 7-segment (active-low g..a) to BCD decoder.
// Anything that is not a decimal glyph reports valid_o = 0.
module fnd_seg_to_bcd
  import fnd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] bcd_o
);

  always_comb begin
    valid_o = 1'b1;
    bcd_o   = 4'd0;
    case (seg_i)
      SEG_0: bcd_o = 4'd0;
      SEG_1: bcd_o = 4'd1;
      SEG_2: bcd_o = 4'd2;
      SEG_3: bcd_o = 4'd3;
      SEG_4: bcd_o = 4'd4;
      SEG_5: bcd_o = 4'd5;
      SEG_6: bcd_o = 4'd6;
      SEG_7: bcd_o = 4'd7;
      SEG_8: bcd_o = 4'd8;
      SEG_9: bcd_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Loopback monitor for the 4-digit FND scan bus: settle, decode, reassemble.
// Define FND_DECODER_DP_CAPTURE_EN to latch decimal points into dp.
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 400_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  fndCom,
  input  logic [7:0]  fndFont,
  output logic [13:0] number,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic        number_valid,
  output logic        decode_err,
  output logic        seq_err
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] STL_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] STL_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    com_q;
  logic [3:0]    pcom_q;
  logic [6:0]    seg_q;
  logic [6:0]    pseg_q;
  logic          dpi_q;
  logic          pdpi_q;
  logic [SW-1:0] stab_q;
  logic [SW-1:0] stab_d;

  logic          onehot;
  logic          same;
  logic          cap;
  logic [1:0]    idx;
  logic          seg_ok;
  logic [3:0]    bcd;

  fsm_e          state_q;
  logic [1:0]    exp_q;
  logic [TW-1:0] tmo_q;
  logic [2:0][3:0] dg_q;
  logic [2:0]    dps_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      com_q  <= COM_BLANK;
      pcom_q <= COM_BLANK;
      seg_q  <= '1;
      pseg_q <= '1;
      stab_q <= '0;
    end else begin
      com_q  <= fndCom;
      pcom_q <= com_q;
      seg_q  <= fndFont[6:0];
      pseg_q <= seg_q;
      stab_q <= stab_d;
    end
  end

`ifdef FND_DECODER_DP_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dpi_q  <= 1'b0;
      pdpi_q <= 1'b0;
    end else begin
      dpi_q  <= ~fndFont[7];
      pdpi_q <= dpi_q;
    end
  end
`else
  logic unused_dp;
  assign unused_dp = fndFont[7];
  assign dpi_q     = 1'b0;
  assign pdpi_q    = 1'b0;
`endif

  always_comb begin
    onehot = 1'b1;
    idx    = 2'd0;
    case (com_q)
      COM_DIG0: idx = 2'd0;
      COM_DIG1: idx = 2'd1;
      COM_DIG2: idx = 2'd2;
      COM_DIG3: idx = 2'd3;
      default:  onehot = 1'b0;
    endcase
  end

  assign same = (com_q == pcom_q)
             && (seg_q == pseg_q)
             && (dpi_q == pdpi_q);

  // Saturate one above the fire point so a held digit fires only once.
  always_comb begin
    stab_d = '0;
    if (same && onehot) begin
      if (stab_q == STL_MAX) stab_d = STL_MAX;
      else                   stab_d = stab_q + SW'(1);
    end
  end

  assign cap = onehot && (stab_d == STL_LAST);

  fnd_seg_to_bcd u_seg (
    .seg_i   (seg_q),
    .valid_o (seg_ok),
    .bcd_o   (bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      exp_q        <= 2'd0;
      tmo_q        <= '0;
      dg_q         <= '0;
      dps_q        <= '0;
      number       <= '0;
      digits       <= '0;
      dp           <= '0;
      number_valid <= 1'b0;
      decode_err   <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      number_valid <= 1'b0;
      decode_err   <= 1'b0;
      seq_err      <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          exp_q <= 2'd0;
          if (cap && idx == 2'd0) begin
            if (seg_ok) begin
              dg_q[0]  <= bcd;
              dps_q[0] <= dpi_q;
              exp_q    <= 2'd1;
              state_q  <= CAPTURE;
            end else begin
              decode_err <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (cap) begin
            tmo_q <= '0;
            if (!seg_ok) begin
              decode_err <= 1'b1;
              exp_q      <= 2'd0;
              state_q    <= IDLE;
            end else if (idx != exp_q) begin
              seq_err <= 1'b1;
              if (idx == 2'd0) begin
                dg_q[0]  <= bcd;
                dps_q[0] <= dpi_q;
                exp_q    <= 2'd1;
              end else begin
                exp_q   <= 2'd0;
                state_q <= IDLE;
              end
            end else if (exp_q == 2'd3) begin
              number       <= bcd_to_bin({bcd, dg_q[2], dg_q[1], dg_q[0]});
              digits       <= {bcd, dg_q[2], dg_q[1], dg_q[0]};
              dp           <= {dpi_q, dps_q};
              number_valid <= 1'b1;
              exp_q        <= 2'd0;
              state_q      <= IDLE;
            end else begin
              case (exp_q)
                2'd1: begin
                  dg_q[1]  <= bcd;
                  dps_q[1] <= dpi_q;
                end
                2'd2: begin
                  dg_q[2]  <= bcd;
                  dps_q[2] <= dpi_q;
                end
                default: ;
              endcase
              exp_q <= exp_q + 2'd1;
            end
          end else if (tmo_q == TMO_LAST) begin
            seq_err <= 1'b1;
            exp_q   <= 2'd0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Self-checking bench for fnd_scan_decoder: glyph table, directed
// scan sequences, then random scans against a run-length event model.
module tb_fnd_scan_decoder;

  localparam int ST = 4;
  localparam int TO = 64;

`ifdef FND_DECODER_DP_CAPTURE_EN
  localparam logic [7:0] KMASK = 8'hFF;
  localparam bit DPEN = 1'b1;
`else
  localparam logic [7:0] KMASK = 8'h7F;
  localparam bit DPEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fndCom;
  logic [7:0]  fndFont;
  logic [13:0] number;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        number_valid;
  logic        decode_err;
  logic        seq_err;

  always #5 clk = ~clk;

  fnd_scan_decoder #(
    .SETTLE_CYCLES  (ST),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fndCom       (fndCom),
    .fndFont      (fndFont),
    .number       (number),
    .digits       (digits),
    .dp           (dp),
    .number_valid (number_valid),
    .decode_err   (decode_err),
    .seq_err      (seq_err)
  );

  logic [6:0] GLY [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] COMS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct {
    int         num;
    logic [15:0] dg;
    logic [3:0]  dp;
  } frame_t;

  typedef struct {
    logic [3:0] c;
    logic [7:0] f;
  } smp_t;

  typedef struct {
    int         t;
    int         idx;
    logic [6:0] seg;
    bit         dpb;
  } cap_t;

  typedef struct {
    logic [6:0] seg;
    bit         ok;
    int         val;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nv_n  = 0;
  int de_n  = 0;
  int se_n  = 0;
  int last_se = -1;
  int last_de = -1;
  int last_start = 0;
  bit rec = 1'b0;
  frame_t obs [$];
  smp_t   stream [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (number_valid) begin
        nv_n++;
        obs.push_back('{int'(number), digits, dp});
      end
      if (decode_err) begin
        de_n++;
        last_de = cyc;
      end
      if (seq_err) begin
        se_n++;
        last_se = cyc;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic show(input logic [3:0] c, input logic [7:0] f,
                      input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        fndCom     = c;
        fndFont    = f;
        last_start = cyc;
      end
      if (rec) stream.push_back('{c, f});
    end
  endtask

  function automatic logic [7:0] fo(input int d, input bit dpon);
    return {~dpon, GLY[d]};
  endfunction

  task automatic frame(input int d0, input int d1, input int d2,
                       input int d3, input int hold,
                       input logic [3:0] dpm);
    show(COMS[0], fo(d0, dpm[0]), hold);
    show(COMS[1], fo(d1, dpm[1]), hold);
    show(COMS[2], fo(d2, dpm[2]), hold);
    show(COMS[3], fo(d3, dpm[3]), hold);
    show(4'hF, 8'hFF, 4);
  endtask

  function automatic int glyph_val(input logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (GLY[i] == s) return i;
    return -1;
  endfunction

  function automatic int com_idx(input logic [3:0] c);
    for (int i = 0; i < 4; i++)
      if (COMS[i] == c) return i;
    return -1;
  endfunction

  initial begin
    vec_t   tbl [14];
    int     nv0, de0, se0, p, exp_num;
    frame_t expf [$];
    cap_t   caps [$];
    int     rs, capt, ex, lt, e_de, e_se, v, n;
    int     d [4];
    bit     dpa [4];
    int     nd, r;
    logic [3:0] c;
    logic [6:0] sg;

    for (int i = 0; i < 10; i++) tbl[i] = '{GLY[i], 1'b1, i};
    tbl[10] = '{7'h08, 1'b0, 0};
    tbl[11] = '{7'h0E, 1'b0, 0};
    tbl[12] = '{7'h7F, 1'b0, 0};
    tbl[13] = '{7'h3F, 1'b0, 0};

    rst     = 1'b1;
    fndCom  = 4'hF;
    fndFont = 8'hFF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst number", 32'(number), 0);
    chk("rst digits", 32'(digits), 0);
    chk("rst dp", 32'(dp), 0);
    chk("rst valid", 32'(number_valid), 0);
    chk("rst derr", 32'(decode_err), 0);
    chk("rst serr", 32'(seq_err), 0);

    exp_num = 0;
    for (int i = 0; i < 14; i++) begin
      nv0 = nv_n; de0 = de_n; se0 = se_n;
      show(COMS[0], {1'b1, tbl[i].seg}, 6);
      show(COMS[1], fo(0, 0), 6);
      show(COMS[2], fo(0, 0), 6);
      show(COMS[3], fo(0, 0), 6);
      show(4'hF, 8'hFF, 4);
      if (tbl[i].ok) begin
        exp_num = tbl[i].val;
        chk("tbl valid", nv_n - nv0, 1);
        chk("tbl derr", de_n - de0, 0);
      end else begin
        chk("tbl valid", nv_n - nv0, 0);
        chk("tbl derr", de_n - de0, 1);
      end
      chk("tbl number", 32'(number), exp_num);
      chk("tbl serr", se_n - se0, 0);
    end

    nv0 = nv_n; de0 = de_n; se0 = se_n;
    frame(4, 3, 2, 1, 10, 4'b0000);
    chk("1234 valid", nv_n - nv0, 1);
    chk("1234 number", 32'(number), 1234);
    chk("1234 digits", 32'(digits), 32'h1234);
    chk("1234 errs", (de_n - de0) + (se_n - se0), 0);

    nv0 = nv_n; de0 = de_n; se0 = se_n;
    show(COMS[0], fo(5, 0), 10);
    show(COMS[1], fo(1, 0), 2);
    show(COMS[1], fo(2, 0), 2);
    show(COMS[1], fo(3, 0), 2);
    show(COMS[1], fo(4, 0), 2);
    show(COMS[1], fo(7, 0), 6);
    show(COMS[2], fo(0, 0), 10);
    show(COMS[3], fo(0, 0), 10);
    show(4'hF, 8'hFF, 4);
    chk("glitch valid", nv_n - nv0, 1);
    chk("glitch number", 32'(number), 75);
    chk("glitch errs", (de_n - de0) + (se_n - se0), 0);

    nv0 = nv_n; se0 = se_n;
    show(COMS[0], fo(1, 0), 10);
    show(COMS[2], fo(1, 0), 10);
    p = last_start;
    show(4'hF, 8'hFF, 80);
    chk("order serr", se_n - se0, 1);
    chk("order serr time", last_se, p + ST + 1);
    chk("order valid", nv_n - nv0, 0);

    nv0 = nv_n; de0 = de_n;
    show(COMS[0], fo(1, 0), 10);
    show(COMS[1], fo(2, 0), 10);
    show(COMS[2], 8'h88, 10);
    p = last_start;
    show(COMS[3], fo(3, 0), 10);
    show(4'hF, 8'hFF, 4);
    chk("inval derr", de_n - de0, 1);
    chk("inval derr time", last_de, p + ST + 1);
    chk("inval valid", nv_n - nv0, 0);
    chk("inval number", 32'(number), 75);

    nv0 = nv_n; se0 = se_n;
    show(COMS[0], fo(1, 0), 10);
    show(COMS[1], fo(2, 0), 10);
    p = last_start;
    show(4'hF, 8'hFF, 70);
    chk("tmo serr", se_n - se0, 1);
    chk("tmo serr time", last_se, p + ST + TO + 1);
    frame(9, 0, 0, 0, 10, 4'b0000);
    chk("tmo valid", nv_n - nv0, 1);
    chk("tmo number", 32'(number), 9);

    frame(5, 6, 7, 8, 10, 4'b0100);
    chk("dp number", 32'(number), 8765);
    chk("dp value", 32'(dp), DPEN ? 32'h4 : 32'h0);

    nv0 = nv_n; de0 = de_n; se0 = se_n;
    show(COMS[0], fo(1, 0), 10);
    show(COMS[1], fo(2, 0), 10);
    @(posedge clk);
    #1 rst = 1'b1;
    show(4'hF, 8'hFF, 3);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid rst number", 32'(number), 0);
    chk("mid rst dp", 32'(dp), 0);
    show(COMS[2], fo(3, 0), 10);
    show(COMS[3], fo(4, 0), 10);
    show(4'hF, 8'hFF, 10);
    chk("mid rst events", (nv_n - nv0) + (de_n - de0) + (se_n - se0), 0);

    show(4'hF, 8'hFF, 80);
    obs.delete();
    stream.delete();
    de0 = de_n; se0 = se_n;
    rec = 1'b1;
    nd = 0;
    for (int s = 0; s < 150; s++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) begin
        c = COMS[nd];
        nd = (nd + 1) % 4;
      end else if (r < 80) c = COMS[$urandom_range(0, 3)];
      else if (r < 92)     c = 4'hF;
      else                 c = 4'b1100;
      if ($urandom_range(0, 9) < 9) sg = GLY[$urandom_range(0, 9)];
      else                          sg = 7'($urandom);
      show(c, {1'($urandom_range(0, 1)), sg}, int'($urandom_range(1, 10)));
    end
    show(4'hF, 8'hFF, 90);
    rec = 1'b0;
    repeat (3) @(negedge clk);

    n = stream.size();
    rs = 0;
    for (int k = 0; k < n; k++) begin
      if (k == 0 || (stream[k].f & KMASK) != (stream[k-1].f & KMASK)
          || stream[k].c != stream[k-1].c)
        rs = k;
      if (k - rs + 1 == ST && com_idx(stream[k].c) >= 0)
        caps.push_back('{rs + ST, com_idx(stream[k].c),
                         stream[k].f[6:0], DPEN & ~stream[k].f[7]});
    end

    capt = 0; ex = 0; lt = 0; e_de = 0; e_se = 0;
    foreach (caps[i]) begin
      if (capt != 0 && caps[i].t - lt > TO) begin
        e_se++;
        capt = 0;
      end
      v = glyph_val(caps[i].seg);
      if (capt == 0) begin
        if (caps[i].idx == 0) begin
          if (v >= 0) begin
            d[0] = v; dpa[0] = caps[i].dpb;
            capt = 1; ex = 1; lt = caps[i].t;
          end else e_de++;
        end
      end else begin
        lt = caps[i].t;
        if (v < 0) begin
          e_de++;
          capt = 0;
        end else if (caps[i].idx != ex) begin
          e_se++;
          if (caps[i].idx == 0) begin
            d[0] = v; dpa[0] = caps[i].dpb; ex = 1;
          end else capt = 0;
        end else begin
          d[ex] = v; dpa[ex] = caps[i].dpb;
          if (ex == 3) begin
            expf.push_back('{d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0],
                             {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])},
                             {dpa[3], dpa[2], dpa[1], dpa[0]}});
            capt = 0;
          end else ex++;
        end
      end
    end
    if (capt != 0) e_se++;

    chk("rnd frames", obs.size(), expf.size());
    chk("rnd derr", de_n - de0, e_de);
    chk("rnd serr", se_n - se0, e_se);
    for (int i = 0; i < obs.size() && i < expf.size(); i++) begin
      chk("rnd number", obs[i].num, expf[i].num);
      chk("rnd digits", 32'(obs[i].dg), 32'(expf[i].dg));
      chk("rnd dp", 32'(obs[i].dp), 32'(expf[i].dp));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fnd_scan_decoder.md
# fnd_scan_decoder

Receive-side decoder for the multiplexed 4-digit FND scan bus: samples the active-low digit-select (fndCom) and segment (fndFont) lines, waits for each digit's segment pattern to settle, and decodes that pattern back to a BCD digit. It reassembles the digit-0..3 sequence into a 14-bit decimal value with a valid pulse. It sits on the display bus as a loopback monitor, for self-check and for feeding the displayed value back into control logic. It flags malformed patterns and broken scan sequences.

## Interface
- SETTLE_CYCLES, 4: consecutive identical samples required before a digit is latched (min 1).
- TIMEOUT_CYCLES, 400_000: max cycles between digit captures inside a frame.
- clk  input  1  system clock.
- rst  input  1  reset: asynchronous, active-high.
- fndCom  input  4  digit select, active-low one-hot (1110 = digit 0 … 0111 = digit 3).
- fndFont  input  8  segments, active-low; bit7 = dp, bits6:0 = g..a.
- number  output  14  decoded value d3*1000+d2*100+d1*10+d0, registered.
- digits  output  16  {d3,d2,d1,d0} BCD, registered with number.
- dp  output  4  captured decimal points, active-high per digit.
- number_valid  output  1  one-cycle pulse; number/digits/dp updated.
- decode_err  output  1  one-cycle pulse; settled segment pattern not a decimal glyph.
- seq_err  output  1  one-cycle pulse; out-of-order digit or timeout.

## Operation
- Input stage: fndCom/fndFont registered once. All following logic uses the registered copies.
- Stability counter: cleared to 0 when the {com, font} sample differs from the previous sample, or when com is not one-hot-low (e.g. 1111 blanking, or multiple digits low). Otherwise increments, saturating.
- Capture event: counter reaches SETTLE_CYCLES-1 on a one-hot-low com. Fires exactly once per stable period; the counter saturates and does not refire.
- Segment decode, bits6:0:
  - 40 → 0, 79 → 1, 24 → 2, 30 → 3, 19 → 4, 12 → 5, 02 → 6, 78 → 7, 00 → 8, 10 → 9.
  - Any other pattern, including the A–F glyphs, is invalid.
- FSM states:
  - IDLE: a valid capture of digit 0 stores d0 and moves to CAPTURE with exp=1. Captures of other digits are ignored silently.
  - CAPTURE: on a valid capture with index == exp, store the digit.
    - If exp == 3: stage the frame and return to IDLE.
    - Otherwise: exp += 1.
  - CAPTURE, index ≠ exp: pulse seq_err.
    - If index == 0: restart with d0 stored and exp=1.
    - Otherwise: go to IDLE.
  - CAPTURE, invalid pattern: pulse decode_err and go to IDLE.
  - CAPTURE, timeout: the cycle counter resets on every capture. When it reaches TIMEOUT_CYCLES-1, pulse seq_err and go to IDLE.
- In IDLE, an invalid pattern on a digit-0 capture pulses decode_err. Invalid patterns on other digits in IDLE are ignored.
- Arithmetic: number is computed from the staged BCD digits with constant multiplies, unsigned, max 9999, fits 14 bits.
- Simultaneous events: a capture in the same cycle as the timeout is processed as a capture and the timeout does not fire.
- The previous number/digits/dp hold until the next complete frame.

## Timing
- Reset values: number=0, digits=0, dp=0, number_valid=0, decode_err=0, seq_err=0; FSM=IDLE, exp=0, all counters 0.
- A capture event occurs SETTLE_CYCLES cycles after the first input edge of a stable period: 1 cycle for the input register plus SETTLE_CYCLES-1 counts.
- number_valid, number, digits and dp are all updated in the same cycle, 1 cycle after the digit-3 capture event.
- Error pulses assert 1 cycle after the offending event.
- Reset asserted mid-frame discards the partial frame immediately. No pulse is generated.

## Configuration
- FND_DECODER_DP_CAPTURE_EN defined:
  - fndFont[7] is latched with each digit into dp (dp = ~fndFont[7]).
  - fndFont[7] is part of the stability comparison.
- Not defined:
  - bit7 is ignored everywhere, including the stability comparison.
  - dp is constant 0.

## Structure
- Package fnd_pkg holds:
  - SEG_0..SEG_9 active-low 7-bit glyph constants.
  - FSM state enum {IDLE, CAPTURE}.
  - COM_DIG0..COM_DIG3 select constants.
- Sub-module fnd_seg_to_bcd: combinational, 7-bit pattern → {valid, bcd[3:0]}. It is instantiated once in fnd_scan_decoder.

## Test plan
Bench uses SETTLE_CYCLES=4 and TIMEOUT_CYCLES=64.
- Scan 1234: digits 0..3 shown as 4,3,2,1, each held 10 cycles → number_valid once, number=1234, digits=16'h1234, no errors.
- Glitch: digit 1 pattern changed every 2 cycles for 8 cycles, then held 6 cycles → exactly one capture, with the final pattern.
- Order: com sequence 0,2 → seq_err 1 cycle after the digit-2 capture, FSM IDLE, no number_valid.
- Invalid glyph: digit 2 shows 7'h08 ("A") → decode_err pulse, partial frame discarded, previous number retained.
- Timeout: digit 0 and digit 1 captured, then com=1111 for 70 cycles → seq_err pulse, after which a full frame 0009 yields number=9.
- DP: with FND_DECODER_DP_CAPTURE_EN and fndFont[7]=0 on digit 2 → dp=4'b0100. Without the macro, the same stimulus → dp=0.
